// File: rtl/sl_preceptron_pkg.sv
// Shared types and sizing helpers for the preceptron weight-SRAM arbiter.
package sl_preceptron_pkg;

    typedef enum logic [1:0] {
        HOST  = 2'd0,
        DRAIN = 2'd1,
        MAC   = 2'd2
    } arb_state_t;

    localparam int unsigned LOCK_TIMEOUT_DEF = 1024;
    localparam int unsigned RD_LATENCY_DEF   = 1;

    // Counter must be able to hold LOCK_TIMEOUT itself so it can saturate there.
    function automatic int unsigned to_cnt_width(input int unsigned lock_timeout);
        return $clog2(lock_timeout + 1);
    endfunction

endpackage

// File: rtl/sl_preceptron_rd_tracker.sv
// Tracks accepted host reads/errors through the SRAM read latency and reports
// how many reads will still be waiting for their response after this cycle.
module sl_preceptron_rd_tracker
    import sl_preceptron_pkg::*;
#(
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int PEND_W     = $clog2(RD_LATENCY + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_rd_i,
    input  logic              push_err_i,
    output logic              head_rd_o,
    output logic              head_err_o,
    output logic [PEND_W-1:0] pending_o
);

    logic [RD_LATENCY-1:0] rd_q, rd_d;
    logic [RD_LATENCY-1:0] err_q, err_d;

    always_comb begin
        rd_d     = '0;
        err_d    = '0;
        rd_d[0]  = push_rd_i;
        err_d[0] = push_err_i;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_d[i]  = rd_q[i-1];
            err_d[i] = err_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            err_q <= '0;
        end else begin
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end

    assign head_rd_o  = rd_q[RD_LATENCY-1];
    assign head_err_o = err_q[RD_LATENCY-1];

    // The head stage responds this cycle, so only the stages behind it are still pending.
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            pending_o = pending_o + PEND_W'(rd_q[i]);
        end
    end

endmodule

// File: rtl/sl_preceptron_mem_arbiter.sv
// Shares the single-port weight SRAM between the host bus and the MAC engine;
// the MAC locks the SRAM for a whole vector once host reads have drained.
module sl_preceptron_mem_arbiter
    import sl_preceptron_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int MEM_ADDR_WIDTH    = 16,
    parameter int SRAM_BASE_ADDRESS = 'h1000,
    parameter int SRAM_DEPTH        = 256,
    parameter int RD_LATENCY        = RD_LATENCY_DEF,
    parameter int LOCK_TIMEOUT      = LOCK_TIMEOUT_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      host_req_valid_i,
    output logic                      host_req_ready_o,
    input  logic                      host_wen_i,
    input  logic [MEM_ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0]     host_wdata_i,
    output logic                      host_rvalid_o,
    output logic [DATA_WIDTH-1:0]     host_rdata_o,
    output logic                      host_err_o,
    input  logic                      mac_lock_req_i,
    output logic                      mac_lock_gnt_o,
    input  logic                      mac_wen_i,
    input  logic                      mac_ren_i,
    input  logic [MEM_ADDR_WIDTH-1:0] mac_addr_i,
    input  logic [DATA_WIDTH-1:0]     mac_wdata_i,
    output logic [DATA_WIDTH-1:0]     mac_rdata_o,
    output logic                      sram_wen_o,
    output logic                      sram_ren_o,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0]     sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     sram_rdata_i,
    output logic                      status_lock_timeout_o
);

    localparam int CNT_W  = to_cnt_width(LOCK_TIMEOUT);
    localparam int PEND_W = $clog2(RD_LATENCY + 1);

    localparam logic [MEM_ADDR_WIDTH-1:0] BASE_C    = MEM_ADDR_WIDTH'(SRAM_BASE_ADDRESS);
    localparam logic [MEM_ADDR_WIDTH:0]   BASE_EXT  = (MEM_ADDR_WIDTH + 1)'(SRAM_BASE_ADDRESS);
    localparam logic [MEM_ADDR_WIDTH:0]   LIMIT_EXT = (MEM_ADDR_WIDTH + 1)'(SRAM_BASE_ADDRESS + SRAM_DEPTH);
    localparam logic [CNT_W-1:0]          TIMEOUT_C = CNT_W'(LOCK_TIMEOUT);

    arb_state_t          state_q;
    logic                gnt_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q;

    logic                in_range;
    logic [MEM_ADDR_WIDTH:0]   addr_ext;
    logic [MEM_ADDR_WIDTH-1:0] host_offset;
    logic                host_ready;
    logic                host_acc;
    logic                head_rd, head_err;
    logic [PEND_W-1:0]   pending;
    logic                go_mac;

    // Host address decode, widened by one bit so base + depth cannot wrap.
    assign addr_ext    = {1'b0, host_addr_i};
    assign in_range    = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
    assign host_offset = host_addr_i - BASE_C;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign host_ready = !rst_i && (state_q == HOST) && !mac_lock_req_i;
    assign host_acc   = host_req_valid_i && host_ready;

    sl_preceptron_rd_tracker #(
        .RD_LATENCY (RD_LATENCY),
        .PEND_W     (PEND_W)
    ) u_rd_tracker (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_rd_i  (host_acc && !host_wen_i),
        .push_err_i (host_acc && !in_range),
        .head_rd_o  (head_rd),
        .head_err_o (head_err),
        .pending_o  (pending)
    );

    assign go_mac = mac_lock_req_i && (pending == '0) &&
                    ((state_q == HOST) || (state_q == DRAIN));

    assign cnt_d = (cnt_q < TIMEOUT_C) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= HOST;
            gnt_q     <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (go_mac) begin
            state_q   <= MAC;
            gnt_q     <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                HOST: begin
                    if (mac_lock_req_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!mac_lock_req_i) state_q <= HOST;
                end
                MAC: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == TIMEOUT_C) timeout_q <= 1'b1;
                    if (!mac_lock_req_i) begin
                        state_q <= HOST;
                        gnt_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= HOST;
                    gnt_q   <= 1'b0;
                end
            endcase
        end
    end

    // SRAM port mux; in the release cycle the MAC strobes are suppressed.
    always_comb begin
        sram_wen_o   = 1'b0;
        sram_ren_o   = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (state_q == MAC) begin
            sram_addr_o  = mac_addr_i;
            sram_wdata_o = mac_wdata_i;
            if (mac_lock_req_i) begin
                sram_wen_o = mac_wen_i;
                sram_ren_o = mac_ren_i;
            end
        end else if (host_acc && in_range) begin
            sram_addr_o  = host_offset;
            sram_wen_o   = host_wen_i;
            sram_ren_o   = !host_wen_i;
            sram_wdata_o = host_wen_i ? host_wdata_i : '0;
        end
    end

    assign host_req_ready_o      = host_ready;
    assign host_rvalid_o         = head_rd;
    assign host_err_o            = head_err;
    assign host_rdata_o          = (head_rd && !head_err) ? sram_rdata_i : '0;
    assign mac_lock_gnt_o        = gnt_q;
    assign mac_rdata_o           = gnt_q ? sram_rdata_i : '0;
    assign status_lock_timeout_o = timeout_q;

endmodule

// File: tb/tb_sl_preceptron_mem_arbiter.sv
// Directed bench: one arbiter with 1-cycle SRAM latency backed by a small SRAM
// model, plus a 3-cycle-latency instance sharing the same stimulus.
module tb_sl_preceptron_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req_valid, host_wen;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        mac_lock_req, mac_wen, mac_ren;
    logic [15:0] mac_addr;
    logic [7:0]  mac_wdata;

    logic        ready, rvalid, err, gnt, sram_wen, sram_ren, timeout;
    logic [7:0]  rdata, mac_rdata, sram_wdata, sram_rdata;
    logic [15:0] sram_addr;

    logic        ready3, rvalid3, err3, gnt3, sram_wen3, sram_ren3, timeout3;
    logic [7:0]  rdata3, mac_rdata3, sram_wdata3;
    logic [7:0]  sram_rdata3 = 8'h00;
    logic [15:0] sram_addr3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sl_preceptron_mem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_valid_i(host_req_valid), .host_req_ready_o(ready),
        .host_wen_i(host_wen), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_rvalid_o(rvalid), .host_rdata_o(rdata), .host_err_o(err),
        .mac_lock_req_i(mac_lock_req), .mac_lock_gnt_o(gnt),
        .mac_wen_i(mac_wen), .mac_ren_i(mac_ren), .mac_addr_i(mac_addr),
        .mac_wdata_i(mac_wdata), .mac_rdata_o(mac_rdata),
        .sram_wen_o(sram_wen), .sram_ren_o(sram_ren), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .status_lock_timeout_o(timeout)
    );

    sl_preceptron_mem_arbiter #(.RD_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .host_req_valid_i(host_req_valid), .host_req_ready_o(ready3),
        .host_wen_i(host_wen), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_rvalid_o(rvalid3), .host_rdata_o(rdata3), .host_err_o(err3),
        .mac_lock_req_i(mac_lock_req), .mac_lock_gnt_o(gnt3),
        .mac_wen_i(mac_wen), .mac_ren_i(mac_ren), .mac_addr_i(mac_addr),
        .mac_wdata_i(mac_wdata), .mac_rdata_o(mac_rdata3),
        .sram_wen_o(sram_wen3), .sram_ren_o(sram_ren3), .sram_addr_o(sram_addr3),
        .sram_wdata_o(sram_wdata3), .sram_rdata_i(sram_rdata3),
        .status_lock_timeout_o(timeout3)
    );

    // 1-cycle-latency SRAM model for the main instance.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (sram_wen) mem[sram_addr[7:0]] <= sram_wdata;
        if (sram_ren) sram_rdata <= mem[sram_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3) ^ 8'h5A;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        host_req_valid = 0; host_wen = 0; host_addr = '0; host_wdata = '0;
        mac_lock_req = 0; mac_wen = 0; mac_ren = 0; mac_addr = '0; mac_wdata = '0;
        tick(); tick();
        settle();
        chk("rst_ready", ready, 0);      chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);      chk("rst_err", err, 0);
        chk("rst_gnt", gnt, 0);          chk("rst_sram_wen", sram_wen, 0);
        chk("rst_sram_ren", sram_ren, 0); chk("rst_sram_addr", sram_addr, 0);
        chk("rst_mac_rdata", mac_rdata, 0); chk("rst_timeout", timeout, 0);
        chk("rst_ready3", ready3, 0);
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_ready", ready, 1); chk("post_rst_ready3", ready3, 1);
        tick();

        // Host write/read in range, including the lowest mapped address.
        host_req_valid = 1; host_wen = 1; host_addr = 16'h1000; host_wdata = 8'h11;
        settle();
        chk("w1000_wen", sram_wen, 1); chk("w1000_addr", sram_addr, 16'h0000);
        chk("w1000_wdata", sram_wdata, 8'h11);
        tick();
        host_addr = 16'h1005; host_wdata = 8'hA5;
        settle();
        chk("w1005_ready", ready, 1); chk("w1005_wen", sram_wen, 1);
        chk("w1005_ren", sram_ren, 0); chk("w1005_addr", sram_addr, 16'h0005);
        chk("w1005_wdata", sram_wdata, 8'hA5);
        tick();
        host_wen = 0; host_wdata = 8'h00;
        settle();
        chk("r1005_ren", sram_ren, 1); chk("r1005_wen", sram_wen, 0);
        chk("r1005_addr", sram_addr, 16'h0005); chk("r1005_rvalid_early", rvalid, 0);
        chk("w_no_err", err, 0);
        tick();
        host_req_valid = 0;
        settle();
        chk("r1005_rvalid", rvalid, 1); chk("r1005_rdata", rdata, 8'hA5);
        chk("r1005_err", err, 0); chk("host_mac_rdata", mac_rdata, 0);
        tick();
        host_req_valid = 1; host_addr = 16'h1000;
        settle();
        chk("r1000_ren", sram_ren, 1); chk("r1000_addr", sram_addr, 16'h0000);
        tick();
        host_req_valid = 0;
        settle();
        chk("r1000_rvalid", rvalid, 1); chk("r1000_rdata", rdata, 8'h11);
        tick();
        settle();
        chk("idle_rvalid", rvalid, 0); chk("idle_rdata", rdata, 0);
        tick();

        // Out-of-range read below base, write at base + depth.
        host_req_valid = 1; host_wen = 0; host_addr = 16'h0FFF;
        settle();
        chk("oor_rd_ready", ready, 1); chk("oor_rd_ren", sram_ren, 0);
        chk("oor_rd_wen", sram_wen, 0);
        tick();
        host_wen = 1; host_addr = 16'h1100; host_wdata = 8'h3C;
        settle();
        chk("oor_wr_wen", sram_wen, 0); chk("oor_wr_ren", sram_ren, 0);
        chk("oor_rd_err", err, 1); chk("oor_rd_rvalid", rvalid, 1);
        chk("oor_rd_rdata", rdata, 0);
        tick();
        host_req_valid = 0; host_wen = 0;
        settle();
        chk("oor_wr_err", err, 1); chk("oor_wr_rvalid", rvalid, 0);
        tick();
        host_req_valid = 1; host_wen = 1; host_addr = 16'h10FF; host_wdata = 8'hC3;
        settle();
        chk("w10ff_err", err, 0); chk("w10ff_wen", sram_wen, 1);
        chk("w10ff_addr", sram_addr, 16'h00FF);
        tick();
        host_wen = 0;
        settle();
        chk("r10ff_ren", sram_ren, 1); chk("r10ff_addr", sram_addr, 16'h00FF);
        tick();
        host_req_valid = 0;
        settle();
        chk("r10ff_rvalid", rvalid, 1); chk("r10ff_rdata", rdata, 8'hC3);
        chk("r10ff_err", err, 0);
        tick(); tick(); tick(); tick();

        // Lock request right after a host read: direct grant at L=1, via DRAIN at L=3.
        host_req_valid = 1; host_wen = 0; host_addr = 16'h1005;
        settle();
        chk("t3_ready_n", ready, 1); chk("t3_ren_n", sram_ren, 1);
        tick();
        host_req_valid = 0; mac_lock_req = 1;
        settle();
        chk("t3_ready_n1", ready, 0); chk("t3_rvalid_n1", rvalid, 1);
        chk("t3_rdata_n1", rdata, 8'hA5); chk("t3_gnt_n1", gnt, 0);
        chk("t3_ready3_n1", ready3, 0); chk("t3_gnt3_n1", gnt3, 0);
        chk("t3_rvalid3_n1", rvalid3, 0);
        tick();
        settle();
        chk("t3_gnt_n2", gnt, 1); chk("t3_rvalid_n2", rvalid, 0);
        chk("t3_gnt3_n2", gnt3, 0); chk("t3_rvalid3_n2", rvalid3, 0);
        tick();
        settle();
        chk("t3_rvalid3_n3", rvalid3, 1); chk("t3_gnt3_n3", gnt3, 0);
        tick();
        settle();
        chk("t3_gnt3_n4", gnt3, 1); chk("t3_rvalid3_n4", rvalid3, 0);
        tick();
        mac_lock_req = 0;
        settle();
        chk("t3_gnt_rel", gnt, 1);
        tick();
        settle();
        chk("t3_gnt_after", gnt, 0); chk("t3_ready_after", ready, 1);
        tick();

        // Simultaneous lock and host request: MAC wins, then 64-word write/read.
        mac_lock_req = 1; host_req_valid = 1; host_wen = 1;
        host_addr = 16'h1010; host_wdata = 8'h77;
        settle();
        chk("t4_ready_p", ready, 0); chk("t4_wen_p", sram_wen, 0);
        tick();
        settle();
        chk("t4_gnt_p1", gnt, 1); chk("t4_ready_p1", ready, 0);
        chk("t4_wen_p1", sram_wen, 0);
        tick();
        for (int i = 0; i < 64; i++) begin
            mac_wen = 1; mac_addr = 16'(i); mac_wdata = pat(i);
            settle();
            chk("t4_mac_wen", sram_wen, 1); chk("t4_mac_waddr", sram_addr, 16'(i));
            chk("t4_mac_wdata", sram_wdata, pat(i));
            tick();
        end
        mac_wen = 0; mac_wdata = '0;
        for (int i = 0; i <= 64; i++) begin
            mac_ren = (i < 64); mac_addr = 16'(i);
            settle();
            if (i > 0) chk("t4_mac_rdata", mac_rdata, pat(i - 1));
            if (i < 64) chk("t4_mac_ren", sram_ren, 1);
            tick();
        end
        mac_lock_req = 0; mac_ren = 0; mac_wen = 1; mac_addr = 16'h0003;
        settle();
        chk("t4_rel_gnt", gnt, 1); chk("t4_rel_wen_forced", sram_wen, 0);
        chk("t4_rel_ready", ready, 0);
        tick();
        mac_wen = 0;
        settle();
        chk("t4_m1_gnt", gnt, 0); chk("t4_m1_ready", ready, 1);
        chk("t4_m1_wen", sram_wen, 1); chk("t4_m1_addr", sram_addr, 16'h0010);
        chk("t4_m1_wdata", sram_wdata, 8'h77);
        tick();
        host_req_valid = 0; host_wen = 0;

        // Long lock: sticky timeout after 1024 owned cycles, cleared on next grant.
        mac_lock_req = 1;
        settle();
        chk("t5_gnt_req", gnt, 0);
        tick();
        for (int k = 0; k < 1100; k++) begin
            settle();
            chk("t5_timeout", timeout, (k >= 1024) ? 1 : 0);
            if (k == 0) chk("t5_gnt", gnt, 1);
            tick();
        end
        mac_lock_req = 0;
        settle();
        chk("t5_rel_timeout", timeout, 1); chk("t5_rel_gnt", gnt, 1);
        tick();
        settle();
        chk("t5_host_timeout", timeout, 1); chk("t5_host_gnt", gnt, 0);
        tick(); tick();
        mac_lock_req = 1;
        settle();
        chk("t5_rereq_timeout", timeout, 1);
        tick();
        settle();
        chk("t5_regrant_gnt", gnt, 1); chk("t5_regrant_timeout", timeout, 0);
        tick();

        // Reset while the L=3 instance is draining an outstanding read.
        mac_lock_req = 0;
        tick();
        host_req_valid = 1; host_wen = 0; host_addr = 16'h1005;
        settle();
        chk("t6_ready3_v", ready3, 1); chk("t6_ren3_v", sram_ren3, 1);
        tick();
        host_req_valid = 0; mac_lock_req = 1;
        settle();
        chk("t6_ready3_v1", ready3, 0); chk("t6_gnt3_v1", gnt3, 0);
        tick();
        settle();
        chk("t6_gnt_v2", gnt, 1); chk("t6_gnt3_drain", gnt3, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt, 0); chk("t6_rst_ready", ready, 0);
        chk("t6_rst_ready3", ready3, 0); chk("t6_rst_gnt3", gnt3, 0);
        chk("t6_rst_rvalid3", rvalid3, 0); chk("t6_rst_err3", err3, 0);
        chk("t6_rst_sram_ren3", sram_ren3, 0); chk("t6_rst_sram_wen", sram_wen, 0);
        chk("t6_rst_mac_rdata", mac_rdata, 0); chk("t6_rst_timeout", timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; mac_lock_req = 0;
        settle();
        chk("t6_v3_rvalid3", rvalid3, 0); chk("t6_v3_ready3", ready3, 1);
        chk("t6_v3_ready", ready, 1); chk("t6_v3_gnt3", gnt3, 0);
        tick();
        settle();
        chk("t6_v4_rvalid3", rvalid3, 0); chk("t6_v4_err3", err3, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
